uart_boot_loader: RTL and testbench

UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

---
 rtl/uart_boot_loader.sv | 172 +++++++++++++++++
 tb/tb_uart_boot_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - UART frame receiver that loads a RAM image and releases the CPU
// Frame: SYNC, LEN_LO, LEN_HI, LEN*4 little-endian data bytes, 8-bit additive checksum.
module uart_boot_loader #(
    parameter int unsigned RAM_WORDS      = 16384,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic [13:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_wmask,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);
    localparam logic [7:0]  ACK         = 8'h06;
    localparam logic [7:0]  NAK         = 8'h15;
    localparam logic [16:0] MAX_LEN     = 17'(RAM_WORDS);
    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_RESP, S_DONE
    } state_t;

    state_t      state_q;
    logic [15:0] len_q;
    logic [15:0] word_idx_q;
    logic [1:0]  byte_cnt_q;
    logic [7:0]  csum_q;
    logic [31:0] asm_q;
    logic [31:0] idle_q;
    logic        tx_valid_q;
    logic [7:0]  tx_data_q;
    logic [13:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;
    logic        cpu_hold_q;
    logic        done_q;
    logic        error_q;

    logic        in_frame;
    logic        timeout;
    logic [31:0] idle_d;
    logic [31:0] word_d;
    logic [15:0] len_d;
    logic [7:0]  csum_d;

    always_comb begin
        in_frame = state_q inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM};
        idle_d   = idle_q + 32'd1;
        timeout  = in_frame && !rx_valid && (idle_d == TIMEOUT_LIM);
        word_d   = asm_q;
        word_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
        len_d    = {rx_data, len_q[7:0]};
        csum_d   = csum_q + rx_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            csum_q     <= '0;
            asm_q      <= '0;
            idle_q     <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            wmask_q <= 4'h0;
            idle_q  <= (in_frame && !rx_valid) ? idle_d : 32'd0;
            if (timeout) begin
                // A partially assembled word is simply dropped here.
                state_q    <= S_RESP;
                tx_valid_q <= 1'b1;
                tx_data_q  <= NAK;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (rx_valid && rx_data == SYNC_BYTE) begin
                            state_q    <= S_LEN_LO;
                            error_q    <= 1'b0;
                            csum_q     <= '0;
                            word_idx_q <= '0;
                            byte_cnt_q <= '0;
                        end
                    end
                    S_LEN_LO: begin
                        if (rx_valid) begin
                            len_q[7:0] <= rx_data;
                            state_q    <= S_LEN_HI;
                        end
                    end
                    S_LEN_HI: begin
                        if (rx_valid) begin
                            len_q <= len_d;
                            if ({1'b0, len_d} > MAX_LEN) begin
                                state_q    <= S_RESP;
                                tx_valid_q <= 1'b1;
                                tx_data_q  <= NAK;
                            end else if (len_d == 16'd0) begin
                                state_q <= S_CSUM;
                            end else begin
                                state_q <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (rx_valid) begin
                            csum_q     <= csum_d;
                            asm_q      <= word_d;
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                            if (byte_cnt_q == 2'd3) begin
                                wmask_q    <= 4'hF;
                                addr_q     <= word_idx_q[13:0];
                                wdata_q    <= word_d;
                                word_idx_q <= word_idx_q + 16'd1;
                                if (word_idx_q == len_q - 16'd1) begin
                                    state_q <= S_CSUM;
                                end
                            end
                        end
                    end
                    S_CSUM: begin
                        if (rx_valid) begin
                            state_q    <= S_RESP;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= (rx_data == csum_q) ? ACK : NAK;
                        end
                    end
                    S_RESP: begin
                        if (tx_ready) begin
                            tx_valid_q <= 1'b0;
                            if (tx_data_q == ACK) begin
                                state_q    <= S_DONE;
                                cpu_hold_q <= 1'b0;
                                done_q     <= 1'b1;
                            end else begin
                                state_q <= S_IDLE;
                                error_q <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_wmask = wmask_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign error     = error_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - self-checking bench for uart_boot_loader
// Directed scenarios plus randomized frames scored against a frame-level model.
module tb_uart_boot_loader;
    localparam int TO = 60;

    logic        clk = 1'b0;
    logic        reset, rx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        tx_valid, cpu_hold, done, error;
    logic [7:0]  tx_data;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wmask;

    always #5 clk = ~clk;

    uart_boot_loader #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];
    typedef struct packed { logic [13:0] a; logic [31:0] d; logic [3:0] m; } wr_t;

    wr_t        wr_q[$];
    logic [7:0] tx_q[$];
    int         checks = 0;
    int         errors = 0;
    int         last_wait = 0;

    always @(negedge clk) begin
        if (ram_wmask != 4'h0) wr_q.push_back({ram_addr, ram_wdata, ram_wmask});
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; rx_valid = 1'b0; tx_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        wr_q.delete(); tx_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1; rx_data = b;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_frame(input bq_t f, input int maxgap);
        foreach (f[i]) send_byte(f[i], $urandom_range(maxgap, 0));
    endtask

    // Reference: what a frame should produce, from the frame format alone.
    function automatic void model(input bq_t f, output logic [7:0] resp, output wq_t words);
        int len;
        logic [7:0]  sum = 8'h00;
        logic [31:0] w;
        words = {};
        len = int'(f[2]) * 256 + int'(f[1]);
        if (len > 16384) begin
            resp = 8'h15;
            return;
        end
        for (int i = 0; i < len; i++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++) begin
                w   = w + (32'(f[3 + 4*i + k]) << (8*k));
                sum = sum + f[3 + 4*i + k];
            end
            words.push_back(w);
        end
        resp = (f[3 + 4*len] == sum) ? 8'h06 : 8'h15;
    endfunction

    function automatic bq_t mk_frame(input int len, input bit bad);
        bq_t f;
        logic [7:0] sum = 8'h00;
        logic [7:0] b;
        logic [15:0] l16 = 16'(len);
        f = {8'hA5, l16[7:0], l16[15:8]};
        for (int i = 0; i < 4*len; i++) begin
            b = 8'($urandom);
            sum = sum + b;
            f.push_back(b);
        end
        f.push_back(bad ? sum + 8'h01 : sum);
        return f;
    endfunction

    task automatic wait_tx(output logic [7:0] b);
        int n = 0;
        while (tx_q.size() == 0 && n < 4*TO) begin tick(); n++; end
        last_wait = n;
        check("tx_seen", 64'(tx_q.size() != 0), 64'(1));
        b = (tx_q.size() != 0) ? tx_q.pop_front() : 8'h00;
        check("tx_drop", 64'(tx_valid), 64'(0));
    endtask

    task automatic check_writes(input string tag, input wq_t exp);
        check({tag, "_nwr"}, 64'(wr_q.size()), 64'(exp.size()));
        foreach (exp[i]) begin
            if (i < wr_q.size()) begin
                check({tag, "_addr"}, 64'(wr_q[i].a), 64'(i));
                check({tag, "_data"}, 64'(wr_q[i].d), 64'(exp[i]));
                check({tag, "_mask"}, 64'(wr_q[i].m), 64'(4'hF));
            end
        end
        wr_q.delete();
    endtask

    task automatic check_frame(input string tag, input bq_t f);
        logic [7:0] er, b;
        wq_t ew;
        model(f, er, ew);
        wait_tx(b);
        check({tag, "_resp"}, 64'(b), 64'(er));
        check_writes(tag, ew);
        check({tag, "_done"}, 64'(done), 64'(er == 8'h06));
        check({tag, "_hold"}, 64'(cpu_hold), 64'(er != 8'h06));
        check({tag, "_err"}, 64'(error), 64'(er != 8'h06));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_hold"}, 64'(cpu_hold), 64'(1));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_err"}, 64'(error), 64'(0));
        check({tag, "_txv"}, 64'(tx_valid), 64'(0));
        check({tag, "_txd"}, 64'(tx_data), 64'(0));
        check({tag, "_mask"}, 64'(ram_wmask), 64'(0));
        check({tag, "_addr"}, 64'(ram_addr), 64'(0));
        check({tag, "_wdata"}, 64'(ram_wdata), 64'(0));
    endtask

    initial begin
        bq_t f, good;
        wq_t ew;
        logic [7:0] b, d0;
        int n;

        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        tick(); tick();
        check_reset_vals("rst");
        reset = 1'b0;
        tick();

        // Bad checksum, then a good load with error clearing on SYNC.
        f    = {8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAB};
        good = {8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
        send_frame(f, 2);
        check_frame("badcs", f);
        send_byte(8'hA5, 0);
        check("err_clr", 64'(error), 64'(0));
        for (int i = 1; i < good.size(); i++) send_byte(good[i], $urandom_range(2, 0));
        check_frame("good", good);
        // DONE ignores everything.
        send_frame(good, 1);
        repeat (5) tick();
        check("done_nwr", 64'(wr_q.size()), 64'(0));
        check("done_ntx", 64'(tx_q.size()), 64'(0));
        check("done_stay", 64'(done), 64'(1));

        // Oversize length, then empty image.
        do_reset();
        f = {8'hA5, 8'h01, 8'h40};
        send_frame(f, 1);
        check_frame("big", f);
        f = {8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(f, 1);
        check_frame("empty", f);

        // Timeout in the second word.
        do_reset();
        f = {8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_frame(f, 0);
        wait_tx(b);
        check("to_resp", 64'(b), 64'(8'h15));
        check("to_lat", 64'(last_wait >= TO && last_wait <= TO + 2), 64'(1));
        ew = {32'h04030201};
        check_writes("to", ew);
        check("to_err", 64'(error), 64'(1));
        check("to_hold", 64'(cpu_hold), 64'(1));

        // Back-pressure on the response.
        do_reset();
        tx_ready = 1'b0;
        f = mk_frame(1, 1'b0);
        send_frame(f, 1);
        n = 0;
        while (!tx_valid && n < 20) begin tick(); n++; end
        check("bp_txv", 64'(tx_valid), 64'(1));
        d0 = tx_data;
        check("bp_ack", 64'(d0), 64'(8'h06));
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_v", 64'(tx_valid), 64'(1));
            check("bp_hold_d", 64'(tx_data), 64'(d0));
            check("bp_hold_c", 64'(cpu_hold), 64'(1));
        end
        tx_ready = 1'b1;
        tick();
        check("bp_txv0", 64'(tx_valid), 64'(0));
        check("bp_rel", 64'(cpu_hold), 64'(0));
        check("bp_done", 64'(done), 64'(1));
        tx_q.delete();
        model(f, b, ew);
        check_writes("bp", ew);

        // Reset in the middle of the second word.
        do_reset();
        f = {8'hA5, 8'h02, 8'h00};
        for (int i = 0; i < 6; i++) f.push_back(8'($urandom));
        send_frame(f, 1);
        reset = 1'b1;
        tick();
        check_reset_vals("mid");
        tick(); tick();
        check("mid_nwr", 64'(wr_q.size()), 64'(1));
        reset = 1'b0;
        tick();
        wr_q.delete(); tx_q.delete();
        f = mk_frame(1, 1'b0);
        send_frame(f, 2);
        check_frame("after", f);

        // Randomized frames with leading noise.
        for (int it = 0; it < 8; it++) begin
            do_reset();
            repeat ($urandom_range(2, 0)) begin
                b = 8'($urandom);
                send_byte((b == 8'hA5) ? 8'h00 : b, 1);
            end
            if ($urandom_range(7, 0) == 0) begin
                n = 16385 + $urandom_range(100, 0);
                f = {8'hA5, 8'(n), 8'(n >> 8)};
            end else begin
                f = mk_frame($urandom_range(5, 0), 1'($urandom_range(1, 0)));
            end
            send_frame(f, 3);
            check_frame("rnd", f);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
